// File: rtl/clock_pkg.sv
// Shared time types, limits and helpers for the alarm clock block.
// Latency: none, types and pure functions only.
// Backpressure: not applicable.
package clock_pkg;

  localparam int MAX_HOURS   = 23;
  localparam int MAX_MINS    = 59;
  localparam int MAX_SECS    = 59;
  localparam int SW_MAX_MINS = 99;

  typedef struct packed {
    logic [4:0] hours;
    logic [5:0] mins;
    logic [5:0] secs;
  } hms_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RING    = 2'd1,
    SNOOZED = 2'd2
  } buzz_state_t;

  typedef enum logic [1:0] {
    SW_IDLE = 2'd0,
    SW_RUN  = 2'd1,
    SW_HOLD = 2'd2
  } sw_state_t;

  // True when every field of a time value is inside the 24-hour range.
  function automatic logic hms_valid(input hms_t t);
    return (t.hours <= 5'(MAX_HOURS)) &&
           (t.mins  <= 6'(MAX_MINS))  &&
           (t.secs  <= 6'(MAX_SECS));
  endfunction

  // One-second advance with carries; 23:59:59 wraps to 00:00:00.
  function automatic hms_t hms_inc(input hms_t t);
    hms_t r;
    r = t;
    if (t.secs != 6'(MAX_SECS)) begin
      r.secs = t.secs + 6'd1;
    end else begin
      r.secs = '0;
      if (t.mins != 6'(MAX_MINS)) begin
        r.mins = t.mins + 6'd1;
      end else begin
        r.mins  = '0;
        r.hours = (t.hours == 5'(MAX_HOURS)) ? 5'd0 : t.hours + 5'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// One-second prescaler: counts clk cycles 0..TICK_DIV-1 while run is high.
// Latency: tick is high during the cycle the counter sits at TICK_DIV-1.
// Backpressure: none; run=0 freezes the count, clr restarts the second.
module sec_prescaler #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt;

  // Cycle counter; clr wins over run so a time load starts a fresh second.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      if (cnt == CW'(TICK_DIV - 1)) cnt <= '0;
      else                          cnt <= cnt + 1'b1;
    end
  end

  assign tick = run && (cnt == CW'(TICK_DIV - 1));

endmodule

// File: rtl/multi_alarm_clock.sv
// 24h timekeeper with alarm slots, buzzer FSM and stopwatch (MULTI_ALARM_CLOCK_STOPWATCH_EN).
// Latency: time, buzzer and stopwatch update on the clk edge after tick or a control pulse.
// Backpressure: none; all controls are single-cycle pulses acted on immediately.
module multi_alarm_clock
  import clock_pkg::*;
#(
  parameter int TICK_DIV    = 100_000_000,
  parameter int NUM_ALARMS  = 4,
  parameter int BUZZ_SECS   = 30,
  parameter int SNOOZE_SECS = 300,
  parameter int IDXW        = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  load,
  input  logic [4:0]            load_hours,
  input  logic [5:0]            load_mins,
  input  logic [5:0]            load_secs,
  input  logic                  alarm_wr,
  input  logic [IDXW-1:0]       alarm_idx,
  input  logic [4:0]            alarm_hours,
  input  logic [5:0]            alarm_mins,
  input  logic [5:0]            alarm_secs,
  input  logic                  alarm_en,
  input  logic                  alarm_ack,
  input  logic                  snooze,
  input  logic                  sw_start,
  input  logic                  sw_stop,
  input  logic                  sw_clear,
  output logic [4:0]            hours,
  output logic [5:0]            mins,
  output logic [5:0]            secs,
  output logic [6:0]            sw_mins,
  output logic [5:0]            sw_secs,
  output logic                  tick,
  output logic                  buzzer,
  output logic [NUM_ALARMS-1:0] alarm_hit
);

  localparam int BZ_MAX = (BUZZ_SECS > SNOOZE_SECS) ? BUZZ_SECS : SNOOZE_SECS;
  localparam int CNTW   = $clog2(BZ_MAX + 1);

  hms_t now_t, now_inc, load_t, wr_t;
  logic load_ok, wr_ok, tick_adv;

  assign load_t   = '{hours: load_hours, mins: load_mins, secs: load_secs};
  assign wr_t     = '{hours: alarm_hours, mins: alarm_mins, secs: alarm_secs};
  assign load_ok  = load && hms_valid(load_t);
  // The index may be wider than the slot count, so range-check it explicitly.
  assign wr_ok    = alarm_wr && hms_valid(wr_t) && (32'(alarm_idx) < NUM_ALARMS);
  assign now_inc  = hms_inc(now_t);
  // A tick in the same cycle as an accepted load is swallowed by the load.
  assign tick_adv = tick && !load_ok;

  sec_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .clr   (load_ok),
    .tick  (tick)
  );

  // Current time register; load has priority over the tick advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         now_t <= '0;
    else if (load_ok)  now_t <= load_t;
    else if (tick_adv) now_t <= now_inc;
  end

  assign hours = now_t.hours;
  assign mins  = now_t.mins;
  assign secs  = now_t.secs;

  hms_t                  slot_t [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] slot_en;
  logic [NUM_ALARMS-1:0] match;

  // Alarm slot bank; rejected writes leave every slot untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_en <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) slot_t[i] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (alarm_idx == IDXW'(i)) begin
          slot_t[i]  <= wr_t;
          slot_en[i] <= alarm_en;
        end
      end
    end
  end

  // Compare against the value the tick is about to produce, so the buzzer
  // rises on the same edge that shows the matching time.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_ALARMS; i++)
      match[i] = tick_adv && slot_en[i] && (slot_t[i] == now_inc);
  end

  buzz_state_t           bz_state, bz_next;
  logic [CNTW-1:0]       bz_cnt, bz_cnt_next;
  logic [NUM_ALARMS-1:0] hit_next;

  // Buzzer state, duration counter and sticky hit mask.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bz_state  <= IDLE;
      bz_cnt    <= '0;
      alarm_hit <= '0;
    end else begin
      bz_state  <= bz_next;
      bz_cnt    <= bz_cnt_next;
      alarm_hit <= hit_next;
    end
  end

  // Buzzer next state: match beats ack, ack beats snooze, both beat timeouts.
  always_comb begin
    bz_next     = bz_state;
    bz_cnt_next = bz_cnt;
    hit_next    = alarm_hit;
    case (bz_state)
      IDLE: begin
        if (|match) begin
          bz_next     = RING;
          bz_cnt_next = '0;
          hit_next    = match;
        end
      end
      RING: begin
        if (|match) begin
          bz_cnt_next = '0;
          hit_next    = alarm_hit | match;
        end else if (alarm_ack) begin
          bz_next     = IDLE;
          bz_cnt_next = '0;
          hit_next    = '0;
        end else if (snooze) begin
          bz_next     = SNOOZED;
          bz_cnt_next = '0;
        end else if (tick) begin
          if (bz_cnt == CNTW'(BUZZ_SECS - 1)) begin
            bz_next     = IDLE;
            bz_cnt_next = '0;
            hit_next    = '0;
          end else begin
            bz_cnt_next = bz_cnt + 1'b1;
          end
        end
      end
      SNOOZED: begin
        if (|match) begin
          bz_next     = RING;
          bz_cnt_next = '0;
          hit_next    = alarm_hit | match;
        end else if (alarm_ack) begin
          bz_next     = IDLE;
          bz_cnt_next = '0;
          hit_next    = '0;
        end else if (tick) begin
          if (bz_cnt == CNTW'(SNOOZE_SECS - 1)) begin
            bz_next     = RING;
            bz_cnt_next = '0;
          end else begin
            bz_cnt_next = bz_cnt + 1'b1;
          end
        end
      end
      default: begin
        bz_next     = IDLE;
        bz_cnt_next = '0;
        hit_next    = '0;
      end
    endcase
  end

  assign buzzer = (bz_state == RING);

`ifdef MULTI_ALARM_CLOCK_STOPWATCH_EN
  sw_state_t  sw_state, sw_next;
  logic [6:0] sw_m, sw_m_next;
  logic [5:0] sw_s, sw_s_next;
  logic       sw_both;

  // start and stop together cancel each other out.
  assign sw_both = sw_start && sw_stop;

  // Stopwatch state and value registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_state <= SW_IDLE;
      sw_m     <= '0;
      sw_s     <= '0;
    end else begin
      sw_state <= sw_next;
      sw_m     <= sw_m_next;
      sw_s     <= sw_s_next;
    end
  end

  // Stopwatch next state; the value only moves on ticks while running.
  always_comb begin
    sw_next   = sw_state;
    sw_m_next = sw_m;
    sw_s_next = sw_s;
    case (sw_state)
      SW_IDLE: begin
        sw_m_next = '0;
        sw_s_next = '0;
        if (sw_start && !sw_both) sw_next = SW_RUN;
      end
      SW_RUN: begin
        if (tick) begin
          if (sw_s == 6'(MAX_SECS)) begin
            sw_s_next = '0;
            sw_m_next = (sw_m == 7'(SW_MAX_MINS)) ? 7'd0 : sw_m + 7'd1;
          end else begin
            sw_s_next = sw_s + 6'd1;
          end
        end
        if (sw_stop && !sw_both) sw_next = SW_HOLD;
      end
      SW_HOLD: begin
        if (!sw_both) begin
          if (sw_start) begin
            sw_next = SW_RUN;
          end else if (sw_clear) begin
            sw_next   = SW_IDLE;
            sw_m_next = '0;
            sw_s_next = '0;
          end
        end
      end
      default: begin
        sw_next   = SW_IDLE;
        sw_m_next = '0;
        sw_s_next = '0;
      end
    endcase
  end

  assign sw_mins = sw_m;
  assign sw_secs = sw_s;
`else
  logic unused_sw_ctl;
  assign unused_sw_ctl = ^{sw_start, sw_stop, sw_clear};
  assign sw_mins       = '0;
  assign sw_secs       = '0;
`endif

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed bench for multi_alarm_clock with a one-second period of four clk cycles.
// Latency: inputs are driven on negedges and outputs sampled on negedges.
// Backpressure: not applicable.
module tb_multi_alarm_clock;

  localparam int TD = 4;
  localparam int NA = 4;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset, run, load;
  logic [4:0]    load_hours;
  logic [5:0]    load_mins, load_secs;
  logic          alarm_wr;
  logic [IW-1:0] alarm_idx;
  logic [4:0]    alarm_hours;
  logic [5:0]    alarm_mins, alarm_secs;
  logic          alarm_en, alarm_ack, snooze, sw_start, sw_stop, sw_clear;
  logic [4:0]    hours;
  logic [5:0]    mins, secs;
  logic [6:0]    sw_mins;
  logic [5:0]    sw_secs;
  logic          tick, buzzer;
  logic [NA-1:0] alarm_hit;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0]  h;
    logic [5:0]  m;
    logic [5:0]  s;
    int          nt;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs [10];

  multi_alarm_clock #(
    .TICK_DIV(TD), .NUM_ALARMS(NA), .BUZZ_SECS(30), .SNOOZE_SECS(300), .IDXW(IW)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .load(load),
    .load_hours(load_hours), .load_mins(load_mins), .load_secs(load_secs),
    .alarm_wr(alarm_wr), .alarm_idx(alarm_idx),
    .alarm_hours(alarm_hours), .alarm_mins(alarm_mins), .alarm_secs(alarm_secs),
    .alarm_en(alarm_en), .alarm_ack(alarm_ack), .snooze(snooze),
    .sw_start(sw_start), .sw_stop(sw_stop), .sw_clear(sw_clear),
    .hours(hours), .mins(mins), .secs(secs),
    .sw_mins(sw_mins), .sw_secs(sw_secs),
    .tick(tick), .buzzer(buzzer), .alarm_hit(alarm_hit)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] hms(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  function automatic logic [31:0] now_v();
    return 32'({hours, mins, secs});
  endfunction

  function automatic logic [31:0] sw_v();
    return 32'({sw_mins, sw_secs});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Returns at the negedge where tick is high (the next posedge commits it).
  task automatic wait_tick_hi();
    int k;
    k = 0;
    while (tick !== 1'b1 && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (tick !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL tick_timeout: no tick within %0d cycles", k);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      wait_tick_hi();
      @(negedge clk);
    end
  endtask

  task automatic do_load(input int h, input int m, input int s);
    load_hours = 5'(h);
    load_mins  = 6'(m);
    load_secs  = 6'(s);
    load       = 1'b1;
    @(negedge clk);
    load       = 1'b0;
  endtask

  task automatic do_wr(input int idx, input int h, input int m, input int s, input logic en);
    alarm_idx   = IW'(idx);
    alarm_hours = 5'(h);
    alarm_mins  = 6'(m);
    alarm_secs  = 6'(s);
    alarm_en    = en;
    alarm_wr    = 1'b1;
    @(negedge clk);
    alarm_wr    = 1'b0;
  endtask

  task automatic pulse_ctl(input logic ack, input logic snz, input logic st,
                           input logic sp, input logic cl);
    alarm_ack = ack;
    snooze    = snz;
    sw_start  = st;
    sw_stop   = sp;
    sw_clear  = cl;
    @(negedge clk);
    alarm_ack = 1'b0;
    snooze    = 1'b0;
    sw_start  = 1'b0;
    sw_stop   = 1'b0;
    sw_clear  = 1'b0;
  endtask

  initial begin
    int k;
    // {load h, m, s, ticks to run, expected time}
    vecs[0] = '{5'd23, 6'd59, 6'd58, 2, hms(0, 0, 0)};
    vecs[1] = '{5'd24, 6'd0,  6'd0,  0, hms(0, 0, 0)};
    vecs[2] = '{5'd12, 6'd60, 6'd0,  1, hms(0, 0, 1)};
    vecs[3] = '{5'd12, 6'd0,  6'd60, 0, hms(0, 0, 1)};
    vecs[4] = '{5'd12, 6'd34, 6'd59, 1, hms(12, 35, 0)};
    vecs[5] = '{5'd10, 6'd59, 6'd59, 1, hms(11, 0, 0)};
    vecs[6] = '{5'd23, 6'd59, 6'd59, 1, hms(0, 0, 0)};
    vecs[7] = '{5'd0,  6'd0,  6'd0,  3, hms(0, 0, 3)};
    vecs[8] = '{5'd23, 6'd59, 6'd0,  0, hms(23, 59, 0)};
    vecs[9] = '{5'd31, 6'd0,  6'd0,  0, hms(23, 59, 0)};

    reset = 1'b1; run = 1'b0; load = 1'b0;
    load_hours = '0; load_mins = '0; load_secs = '0;
    alarm_wr = 1'b0; alarm_idx = '0; alarm_hours = '0; alarm_mins = '0; alarm_secs = '0;
    alarm_en = 1'b0; alarm_ack = 1'b0; snooze = 1'b0;
    sw_start = 1'b0; sw_stop = 1'b0; sw_clear = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("reset_time",   now_v(), 32'(0));
    check("reset_sw",     sw_v(), 32'(0));
    check("reset_buzzer", 32'(buzzer), 32'(0));
    check("reset_hit",    32'(alarm_hit), 32'(0));
    check("reset_tick",   32'(tick), 32'(0));

    // Table of load / advance vectors with run gated to exact tick counts.
    for (int i = 0; i < 10; i++) begin
      run = 1'b0;
      do_load(int'(vecs[i].h), int'(vecs[i].m), int'(vecs[i].s));
      run = 1'b1;
      repeat (vecs[i].nt * TD) @(negedge clk);
      run = 1'b0;
      check($sformatf("vec%0d_time", i), now_v(), 32'(vecs[i].exp));
    end

    // run=0 holds the prescaler: no tick and no time change.
    repeat (10) @(negedge clk);
    check("hold_tick", 32'(tick), 32'(0));
    check("hold_time", now_v(), 32'(hms(23, 59, 0)));

    // First tick lands in cycle TD-1 after run rises, then every TD cycles.
    do_load(0, 0, 0);
    run = 1'b1;
    k = 0;
    while (tick !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    check("first_tick_cycle", 32'(k), 32'(TD - 1));
    k = 0;
    do begin @(negedge clk); k++; end while (tick !== 1'b1 && k < 20);
    check("tick_period", 32'(k), 32'(TD));

    // Slot 0 at 00:00:05: ring, then auto-timeout after 30 ticks.
    do_wr(0, 0, 0, 5, 1'b1);
    do_load(0, 0, 3);
    wait_ticks(1);
    check("pre_match_buzzer", 32'(buzzer), 32'(0));
    wait_ticks(1);
    check("match_time",   now_v(), 32'(hms(0, 0, 5)));
    check("match_buzzer", 32'(buzzer), 32'(1));
    check("match_hit",    32'(alarm_hit), 32'(4'b0001));
    wait_ticks(29);
    check("ring29_buzzer", 32'(buzzer), 32'(1));
    wait_ticks(1);
    check("timeout_buzzer", 32'(buzzer), 32'(0));
    check("timeout_hit",    32'(alarm_hit), 32'(0));

    // Snooze for 300 ticks, re-ring, snooze again, then dismiss.
    do_load(0, 0, 3);
    wait_ticks(2);
    check("ring2_buzzer", 32'(buzzer), 32'(1));
    pulse_ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("snooze_buzzer", 32'(buzzer), 32'(0));
    check("snooze_hit",    32'(alarm_hit), 32'(4'b0001));
    wait_ticks(299);
    check("snooze299_buzzer", 32'(buzzer), 32'(0));
    wait_ticks(1);
    check("rering_buzzer", 32'(buzzer), 32'(1));
    check("rering_hit",    32'(alarm_hit), 32'(4'b0001));
    pulse_ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ack_snoozed_buzzer", 32'(buzzer), 32'(0));
    check("ack_snoozed_hit",    32'(alarm_hit), 32'(0));
    wait_ticks(301);
    check("idle_after_ack_buzzer", 32'(buzzer), 32'(0));

    // Two slots matching together; ack in the matching cycle loses.
    do_wr(0, 0, 0, 5, 1'b0);
    do_wr(1, 0, 0, 10, 1'b1);
    do_wr(2, 0, 0, 10, 1'b1);
    do_load(0, 0, 8);
    wait_ticks(1);
    check("multi_pre_buzzer", 32'(buzzer), 32'(0));
    wait_tick_hi();
    alarm_ack = 1'b1;
    @(negedge clk);
    alarm_ack = 1'b0;
    check("multi_time",   now_v(), 32'(hms(0, 0, 10)));
    check("multi_buzzer", 32'(buzzer), 32'(1));
    check("multi_hit",    32'(alarm_hit), 32'(4'b0110));
    pulse_ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("multi_ack_buzzer", 32'(buzzer), 32'(0));

    // Rejected writes: bad fields on slot 3, out-of-range index 5.
    do_wr(1, 0, 0, 10, 1'b0);
    do_wr(2, 0, 0, 10, 1'b0);
    do_wr(3, 0, 0, 30, 1'b1);
    do_wr(3, 24, 0, 30, 1'b0);
    do_wr(5, 0, 0, 20, 1'b1);
    do_load(0, 0, 30);
    check("load_no_match_buzzer", 32'(buzzer), 32'(0));
    do_load(0, 0, 19);
    wait_ticks(1);
    check("idx5_ignored_buzzer", 32'(buzzer), 32'(0));
    do_load(0, 0, 29);
    wait_ticks(1);
    check("slot3_buzzer", 32'(buzzer), 32'(1));
    check("slot3_hit",    32'(alarm_hit), 32'(4'b1000));
    pulse_ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef MULTI_ALARM_CLOCK_STOPWATCH_EN
    wait_ticks(1);
    pulse_ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_ticks(65);
    check("sw_65", sw_v(), 32'({7'd1, 6'd5}));
    pulse_ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_ticks(3);
    check("sw_hold", sw_v(), 32'({7'd1, 6'd5}));
    pulse_ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_ticks(2);
    check("sw_start_stop_same", sw_v(), 32'({7'd1, 6'd5}));
    pulse_ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_ticks(1);
    check("sw_clear_in_run", sw_v(), 32'({7'd1, 6'd6}));
    pulse_ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("sw_cleared", sw_v(), 32'(0));
    pulse_ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_ticks(5999);
    check("sw_99_59", sw_v(), 32'({7'd99, 6'd59}));
    wait_ticks(1);
    check("sw_wrap", sw_v(), 32'(0));
`else
    pulse_ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_ticks(3);
    check("sw_disabled", sw_v(), 32'(0));
`endif

    // Asynchronous reset while ringing (and stopwatch running when built).
    do_load(0, 0, 29);
    wait_ticks(2);
    check("pre_reset_buzzer", 32'(buzzer), 32'(1));
    reset = 1'b1;
    #1;
    check("async_reset_time",   now_v(), 32'(0));
    check("async_reset_buzzer", 32'(buzzer), 32'(0));
    check("async_reset_hit",    32'(alarm_hit), 32'(0));
    check("async_reset_sw",     sw_v(), 32'(0));
    check("async_reset_tick",   32'(tick), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_load(0, 0, 29);
    wait_ticks(1);
    check("slots_cleared_by_reset", 32'(buzzer), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
